sample_rate_sequencer: RTL and testbench

- Parametrised successor to the DDS front-end sampling controller.
- Divides Fg_CLK into a one-cycle Enable strobe with period RATIO_BASE**Mode, where Mode is in 0..NUM_MODES-1.
- Mode can be stepped up or down by debounced push-buttons, or loaded directly from a host.
- Ready flags that sampling has settled after reset and after every mode change. Enable feeds the sample/phase-accumulator path.

---
 rtl/sample_rate_sequencer_if.sv | 24 ++
 rtl/sample_rate_sequencer.sv | 153 +++++++++++++++
 tb/tb_sample_rate_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_rate_sequencer_if.sv
// Host/button-side signal bundle for the sample-rate sequencer.
// The master drives buttons and mode loads; the slave (sequencer) returns the sampling strobe and status.
interface sample_rate_sequencer_if #(
  parameter int unsigned MODE_W = 4
);
  logic              BtnUp;
  logic              BtnDown;
  logic              ModeLoad;
  logic [MODE_W-1:0] ModeIn;
  logic              Enable;
  logic [MODE_W-1:0] Mode;
  logic              ModeChanged;
  logic              Ready;

  modport master (
    output BtnUp, BtnDown, ModeLoad, ModeIn,
    input  Enable, Mode, ModeChanged, Ready
  );

  modport slave (
    input  BtnUp, BtnDown, ModeLoad, ModeIn,
    output Enable, Mode, ModeChanged, Ready
  );
endinterface

// File: rtl/sample_rate_sequencer.sv
// Divides Fg_CLK into a one-cycle Enable strobe with period RATIO_BASE**Mode.
// Mode is stepped by debounced buttons or loaded directly; Ready flags settled sampling.
module sample_rate_sequencer #(
  parameter int unsigned NUM_MODES    = 5,
  parameter int unsigned RATIO_BASE   = 10,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MODE_W       = 4,
  parameter int unsigned READY_DELAY  = 80,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic                   Fg_CLK,
  input  logic                   RESETn,
  sample_rate_sequencer_if.slave bus
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RDY_W = $clog2(READY_DELAY + 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

  function automatic longint unsigned period_of(input int unsigned m);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < m; i++) p = p * RATIO_BASE;
    return p;
  endfunction

  logic [CNT_W-1:0]  period_m1_lut [NUM_MODES];
  logic [CNT_W-1:0]  period_m1;
  logic [CNT_W-1:0]  cnt;
  logic              enable_q;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_prev;
  logic [MODE_W-1:0] mode_nxt;
  logic              changed_q;
  logic              pend_up;
  logic              pend_dn;
  logic [RDY_W-1:0]  rdy_cnt;
  logic              ready_q;
  logic [1:0]        btn_raw;
  logic [1:0]        rise;

  for (genvar g = 0; g < NUM_MODES; g++) begin : g_lut
    localparam longint unsigned PM1 = period_of(g) - 1;
    assign period_m1_lut[g] = CNT_W'(PM1);
  end

  assign btn_raw = {bus.BtnDown, bus.BtnUp};

  // Index 0 is the up button, index 1 the down button.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic            s1;
    logic            s2;
    logic            stable;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge Fg_CLK) begin
      if (!RESETn) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        stable <= 1'b0;
        db_cnt <= '0;
      end else begin
        s1 <= btn_raw[b];
        s2 <= s1;
        if (s2 != stable) begin
          if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            stable <= s2;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end

    assign rise[b] = s2 & ~stable & (db_cnt == DB_W'(DEBOUNCE_CYC - 1));
  end

  always_comb begin
    mode_nxt = mode_q;
    if (bus.ModeLoad) begin
      mode_nxt = (bus.ModeIn > MODE_MAX) ? MODE_MAX : bus.ModeIn;
    end else if (enable_q && (pend_up != pend_dn)) begin
      if (pend_up) mode_nxt = (mode_q == MODE_MAX) ? '0 : mode_q + 1'b1;
      else         mode_nxt = (mode_q == '0) ? MODE_MAX : mode_q - 1'b1;
    end
  end

  // Period follows the incoming mode so the first interval after a step is P(new).
  always_comb begin
    period_m1 = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++)
      if (mode_nxt == MODE_W'(i)) period_m1 = period_m1_lut[i];
  end

  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      cnt       <= '0;
      enable_q  <= 1'b0;
      mode_q    <= '0;
      mode_prev <= '0;
      changed_q <= 1'b0;
      pend_up   <= 1'b0;
      pend_dn   <= 1'b0;
      rdy_cnt   <= '0;
      ready_q   <= 1'b0;
    end else begin
      mode_q    <= mode_nxt;
      mode_prev <= mode_q;
      changed_q <= (mode_q != mode_prev);

      if (bus.ModeLoad) begin
        cnt      <= '0;
        enable_q <= 1'b0;
        pend_up  <= 1'b0;
        pend_dn  <= 1'b0;
      end else begin
        if (cnt >= period_m1) begin
          enable_q <= 1'b1;
          cnt      <= '0;
        end else begin
          enable_q <= 1'b0;
          cnt      <= cnt + 1'b1;
        end
        // A fresh button edge landing on an Enable edge survives the clear.
        if (enable_q) begin
          pend_up <= rise[0];
          pend_dn <= rise[1];
        end else begin
          pend_up <= pend_up | rise[0];
          pend_dn <= pend_dn | rise[1];
        end
      end

      if (mode_nxt != mode_q) begin
        rdy_cnt <= '0;
        ready_q <= 1'b0;
      end else if (rdy_cnt == RDY_W'(READY_DELAY - 1)) begin
        ready_q <= 1'b1;
      end else begin
        rdy_cnt <= rdy_cnt + 1'b1;
      end
    end
  end

  assign bus.Enable      = enable_q;
  assign bus.Mode        = mode_q;
  assign bus.ModeChanged = changed_q;
  assign bus.Ready       = ready_q;

endmodule

// File: tb/tb_sample_rate_sequencer.sv
// Scoreboard bench for sample_rate_sequencer: the driver queues expected events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sample_rate_sequencer;

  logic Fg_CLK = 1'b0;
  logic RESETn = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   failures = 0;
  logic en_track = 1'b0;
  logic rdy_prev = 1'b0;

  typedef struct {
    int cyc;
    int mode;
  } ev_t;

  ev_t mc_q[$];
  int  rdy_q[$];
  int  en_q[$];

  sample_rate_sequencer_if #(.MODE_W(4)) bus ();

  sample_rate_sequencer #(
    .NUM_MODES   (5),
    .RATIO_BASE  (10),
    .CNT_W       (16),
    .MODE_W      (4),
    .READY_DELAY (80),
    .DEBOUNCE_CYC(16)
  ) dut (
    .Fg_CLK(Fg_CLK),
    .RESETn(RESETn),
    .bus   (bus)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  always @(posedge Fg_CLK) cyc <= RESETn ? cyc + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge Fg_CLK);
      #1;
    end
  endtask

  task automatic push_mc(input int c, input int m);
    ev_t e;
    e.cyc  = c;
    e.mode = m;
    mc_q.push_back(e);
  endtask

  // Monitor
  always @(negedge Fg_CLK) begin
    if (bus.ModeChanged === 1'b1) begin
      if (mc_q.size() == 0) begin
        check("modechanged_unexpected", bus.ModeChanged, 0);
      end else begin
        ev_t e;
        e = mc_q.pop_front();
        check("modechanged_cycle", cyc, e.cyc);
        check("modechanged_mode", bus.Mode, e.mode);
      end
    end
    if (bus.Ready === 1'b1 && rdy_prev === 1'b0) begin
      if (rdy_q.size() == 0) check("ready_rise_unexpected", bus.Ready, 0);
      else check("ready_rise_cycle", cyc, rdy_q.pop_front());
    end
    rdy_prev <= bus.Ready;
    if (en_track && bus.Enable === 1'b1) begin
      if (en_q.size() == 0) check("enable_unexpected", bus.Enable, 0);
      else check("enable_cycle", cyc, en_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.BtnUp    = 1'b0;
    bus.BtnDown  = 1'b0;
    bus.ModeLoad = 1'b0;
    bus.ModeIn   = '0;
    repeat (3) @(posedge Fg_CLK);
    #1;
    check("reset_enable", bus.Enable, 0);
    check("reset_mode", bus.Mode, 0);
    check("reset_modechanged", bus.ModeChanged, 0);
    check("reset_ready", bus.Ready, 0);

    // Mode 0 defaults: Enable every cycle from edge 1, Ready at edge 80
    RESETn = 1'b1;
    en_track = 1'b1;
    for (int i = 1; i <= 10; i++) en_q.push_back(i);
    rdy_q.push_back(80);
    wait_cyc(11);
    en_track = 1'b0;

    // Load mode 2 at edge 200, glitch on BtnUp must be ignored
    wait_cyc(199);
    bus.ModeLoad = 1'b1;
    bus.ModeIn   = 4'd2;
    push_mc(201, 2);
    rdy_q.push_back(280);
    wait_cyc(200);
    bus.ModeLoad = 1'b0;
    en_track = 1'b1;
    en_q.push_back(300);
    en_q.push_back(400);
    wait_cyc(201);
    check("load2_mode", bus.Mode, 2);
    check("load2_ready_low", bus.Ready, 0);
    wait_cyc(210);
    bus.BtnUp = 1'b1;
    wait_cyc(215);
    bus.BtnUp = 1'b0;
    wait_cyc(350);
    check("glitch_mode_kept", bus.Mode, 2);
    wait_cyc(451);
    en_track = 1'b0;

    // ModeIn=7 clamps to 4; BtnUp press wraps to 0 on the Enable at 10500
    wait_cyc(499);
    bus.ModeLoad = 1'b1;
    bus.ModeIn   = 4'd7;
    push_mc(501, 4);
    rdy_q.push_back(580);
    wait_cyc(500);
    bus.ModeLoad = 1'b0;
    wait_cyc(501);
    check("clamp_mode", bus.Mode, 4);
    wait_cyc(600);
    bus.BtnUp = 1'b1;
    push_mc(10502, 0);
    rdy_q.push_back(10581);
    wait_cyc(630);
    bus.BtnUp = 1'b0;
    wait_cyc(10400);
    en_track = 1'b1;
    for (int i = 10500; i <= 10505; i++) en_q.push_back(i);
    wait_cyc(10500);
    check("step_waits_enable_mode", bus.Mode, 4);
    wait_cyc(10506);
    en_track = 1'b0;

    // Mode 1: both buttons before the same Enable cancel out
    wait_cyc(10699);
    bus.ModeLoad = 1'b1;
    bus.ModeIn   = 4'd1;
    push_mc(10701, 1);
    rdy_q.push_back(10780);
    wait_cyc(10700);
    bus.ModeLoad = 1'b0;
    wait_cyc(10750);
    bus.BtnUp   = 1'b1;
    bus.BtnDown = 1'b1;
    wait_cyc(10780);
    bus.BtnUp   = 1'b0;
    bus.BtnDown = 1'b0;
    wait_cyc(10800);
    check("cancel_mode", bus.Mode, 1);

    // Flags were cleared: a lone up step now goes 1 -> 2
    wait_cyc(10850);
    bus.BtnUp = 1'b1;
    push_mc(10872, 2);
    rdy_q.push_back(10951);
    wait_cyc(10880);
    bus.BtnUp = 1'b0;

    // Down step 2 -> 1 on the Enable at 10970, then period 10
    wait_cyc(10900);
    bus.BtnDown = 1'b1;
    push_mc(10972, 1);
    rdy_q.push_back(11051);
    wait_cyc(10930);
    bus.BtnDown = 1'b0;
    wait_cyc(10960);
    en_track = 1'b1;
    en_q.push_back(10970);
    en_q.push_back(10980);
    en_q.push_back(10990);
    en_q.push_back(11000);
    wait_cyc(11001);
    en_track = 1'b0;

    // Down wrap 0 -> 4
    wait_cyc(11099);
    bus.ModeLoad = 1'b1;
    bus.ModeIn   = 4'd0;
    push_mc(11101, 0);
    wait_cyc(11100);
    bus.ModeLoad = 1'b0;
    wait_cyc(11120);
    bus.BtnDown = 1'b1;
    push_mc(11140, 4);
    rdy_q.push_back(11219);
    wait_cyc(11150);
    bus.BtnDown = 1'b0;
    wait_cyc(11250);
    check("wrap_down_mode", bus.Mode, 4);
    check("wrap_down_ready", bus.Ready, 1);

    // One-cycle reset mid-count
    wait_cyc(11300);
    RESETn = 1'b0;
    @(posedge Fg_CLK);
    #1;
    check("midreset_enable", bus.Enable, 0);
    check("midreset_mode", bus.Mode, 0);
    check("midreset_modechanged", bus.ModeChanged, 0);
    check("midreset_ready", bus.Ready, 0);
    RESETn = 1'b1;
    rdy_q.push_back(80);
    @(posedge Fg_CLK);
    #1;
    check("post_reset_enable", bus.Enable, 1);
    check("post_reset_mode", bus.Mode, 0);
    wait_cyc(90);

    check("modechanged_left", mc_q.size(), 0);
    check("ready_left", rdy_q.size(), 0);
    check("enable_left", en_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
